fp32_div_seq: RTL and testbench

//  Iterative IEEE-754 single-precision divider (result = a_operand / b_operand), the inverse datapath of the FP32 multiplier.

---
 rtl/fp32_div_seq_if.sv | 25 ++
 rtl/fp32_div_seq.sv | 202 ++++++++++++++++++++
 tb/tb_fp32_div_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fp32_div_seq_if.sv
// Start/done handshake, operand and result/flag bundle for the FP32 sequential divider.
interface fp32_div_seq_if #(
  parameter int unsigned DWIDTH = 32
);
  logic              start;
  logic [DWIDTH-1:0] a_operand;
  logic [DWIDTH-1:0] b_operand;
  logic              busy;
  logic              done;
  logic [DWIDTH-1:0] result;
  logic              Exception;
  logic              DivByZero;
  logic              Overflow;
  logic              Underflow;

  modport master (
    output start, a_operand, b_operand,
    input  busy, done, result, Exception, DivByZero, Overflow, Underflow
  );

  modport slave (
    input  start, a_operand, b_operand,
    output busy, done, result, Exception, DivByZero, Overflow, Underflow
  );
endinterface

// File: rtl/fp32_div_seq.sv
// Iterative FP32 divider: radix-2 restoring mantissa division, one quotient bit per clock, fixed latency.
// Define FP32_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module fp32_div_seq #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned EWIDTH = 8,
  parameter int unsigned MWIDTH = 23,
  parameter int unsigned BIAS   = 127
) (
  input logic          clk,
  input logic          rst,
  fp32_div_seq_if.slave bus
);

  localparam int unsigned QBITS  = MWIDTH + 3;
  localparam int unsigned RWIDTH = MWIDTH + 2;
  localparam int unsigned XWIDTH = EWIDTH + 2;
  localparam int unsigned MW1    = MWIDTH + 1;
  localparam int unsigned CWIDTH = $clog2(QBITS);

  localparam logic signed [XWIDTH-1:0] EXP_MAX = XWIDTH'((1 << EWIDTH) - 1);
  localparam logic signed [XWIDTH-1:0] EXP_MIN = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_NORM
  } state_t;

  state_t                    state_q;
  logic                      sign_q;
  logic                      exc_in_q;
  logic                      azero_q;
  logic                      bzero_q;
  logic signed [XWIDTH-1:0]  exp_q;
  logic [MWIDTH:0]           mb_q;
  logic [RWIDTH-1:0]         rem_q;
  logic [QBITS-1:0]          q_q;
  logic [CWIDTH-1:0]         cnt_q;

  logic                      busy_q;
  logic                      done_q;
  logic [DWIDTH-1:0]         result_q;
  logic                      exc_q;
  logic                      dbz_q;
  logic                      ovf_q;
  logic                      unf_q;

  logic [EWIDTH-1:0]         ea_w;
  logic [EWIDTH-1:0]         eb_w;
  logic [RWIDTH-1:0]         rem_d;
  logic [QBITS-1:0]          q_d;

  logic [MWIDTH-1:0]         man_n;
  logic signed [XWIDTH-1:0]  e_n;
  logic                      round_up;
  logic [MWIDTH:0]           man_r;
  logic signed [XWIDTH-1:0]  e_r;

  logic [DWIDTH-1:0]         result_d;
  logic                      exc_d;
  logic                      dbz_d;
  logic                      ovf_d;
  logic                      unf_d;

  assign ea_w = bus.a_operand[DWIDTH-2 -: EWIDTH];
  assign eb_w = bus.b_operand[DWIDTH-2 -: EWIDTH];

  // One restoring step: remainder is one bit wider than the divisor so the shifted value never overflows.
  always_comb begin
    rem_d = rem_q;
    q_d   = q_q;
    if (rem_q >= {1'b0, mb_q}) begin
      q_d   = {q_q[QBITS-2:0], 1'b1};
      rem_d = (rem_q - {1'b0, mb_q}) << 1;
    end else begin
      q_d   = {q_q[QBITS-2:0], 1'b0};
      rem_d = rem_q << 1;
    end
  end

  // Quotient lies in (0.5, 2): an integer bit of 0 costs one exponent step.
  always_comb begin
    if (q_q[QBITS-1]) begin
      man_n = q_q[QBITS-2:2];
      e_n   = exp_q;
    end else begin
      man_n = q_q[QBITS-3:1];
      e_n   = exp_q - XWIDTH'(1);
    end
  end

`ifdef FP32_DIV_RNE_EN
  logic guard_b;
  logic sticky_b;

  assign guard_b  = q_q[QBITS-1] ? q_q[1] : q_q[0];
  assign sticky_b = (q_q[QBITS-1] & q_q[0]) | (|rem_q);
  assign round_up = guard_b & (sticky_b | man_n[0]);
`else
  assign round_up = 1'b0;
`endif

  // A carry out of the rounded mantissa leaves its stored bits at zero, so only the exponent moves.
  assign man_r = {1'b0, man_n} + MW1'(round_up);
  assign e_r   = e_n + XWIDTH'(man_r[MWIDTH]);

  always_comb begin
    result_d = '0;
    exc_d    = 1'b0;
    dbz_d    = 1'b0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (exc_in_q) begin
      exc_d = 1'b1;
    end else if (bzero_q) begin
      result_d = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
      dbz_d    = 1'b1;
    end else if (azero_q) begin
      result_d = {sign_q, {(DWIDTH-1){1'b0}}};
    end else if (e_r >= EXP_MAX) begin
      result_d = {sign_q, {EWIDTH{1'b1}}, {MWIDTH{1'b0}}};
      ovf_d    = 1'b1;
    end else if (e_r <= EXP_MIN) begin
      result_d = {sign_q, {(DWIDTH-1){1'b0}}};
      unf_d    = 1'b1;
    end else begin
      result_d = {sign_q, e_r[EWIDTH-1:0], man_r[MWIDTH-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sign_q   <= 1'b0;
      exc_in_q <= 1'b0;
      azero_q  <= 1'b0;
      bzero_q  <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            sign_q   <= bus.a_operand[DWIDTH-1] ^ bus.b_operand[DWIDTH-1];
            exc_in_q <= (&ea_w) | (&eb_w);
            azero_q  <= ~|ea_w;
            bzero_q  <= ~|eb_w;
            exp_q    <= XWIDTH'(ea_w) - XWIDTH'(eb_w) + XWIDTH'(BIAS);
            rem_q    <= RWIDTH'({|ea_w, bus.a_operand[MWIDTH-1:0]});
            mb_q     <= {|eb_w, bus.b_operand[MWIDTH-1:0]};
            q_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_DIV;
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CWIDTH'(1);
          if (cnt_q == CWIDTH'(QBITS - 1)) begin
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          result_q <= result_d;
          exc_q    <= exc_d;
          dbz_q    <= dbz_d;
          ovf_q    <= ovf_d;
          unf_q    <= unf_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.Exception = exc_q;
  assign bus.DivByZero = dbz_q;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed-vector bench for fp32_div_seq: table of quotients/flags plus handshake corner sequences.
module tb_fp32_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fp32_div_seq_if #(.DWIDTH(32)) bus ();

  fp32_div_seq #(
    .DWIDTH(32),
    .EWIDTH(8),
    .MWIDTH(23),
    .BIAS  (127)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  fl;   // {Exception, DivByZero, Overflow, Underflow}
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic logic [3:0] flags_now();
    return {bus.Exception, bus.DivByZero, bus.Overflow, bus.Underflow};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Accept one operation from idle and return the cycle count from the accepting edge to done.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic [3:0] fl,
                        output logic bsy, output int lat);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.a_operand = a;
    bus.b_operand = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.result;
    fl  = flags_now();
    bsy = bus.busy;
  endtask

  initial begin
    logic [31:0] res;
    logic [3:0]  fl;
    logic        bsy;
    int          lat;
    int          ndone;
    int          first_done;
    int          second_done;
    logic [31:0] res1;
    logic [31:0] res2;

    vecs[0]  = '{"6div2",      32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000};
`ifdef FP32_DIV_RNE_EN
    vecs[1]  = '{"1div3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000};
    vecs[2]  = '{"2div3",      32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000};
`else
    vecs[1]  = '{"1div3",      32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000};
    vecs[2]  = '{"2div3",      32'h40000000, 32'h40400000, 32'h3F2AAAAA, 4'b0000};
`endif
    vecs[3]  = '{"1div0",      32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100};
    vecs[4]  = '{"m1div0",     32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100};
    vecs[5]  = '{"0div0",      32'h00000000, 32'h00000000, 32'h7F800000, 4'b0100};
    vecs[6]  = '{"ovf",        32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010};
    vecs[7]  = '{"unf",        32'h00800000, 32'h40000000, 32'h00000000, 4'b0001};
    vecs[8]  = '{"nan_a",      32'h7FC00000, 32'h3F800000, 32'h00000000, 4'b1000};
    vecs[9]  = '{"inf_b",      32'h3F800000, 32'h7F800000, 32'h00000000, 4'b1000};
    vecs[10] = '{"0div2",      32'h00000000, 32'h40000000, 32'h00000000, 4'b0000};
    vecs[11] = '{"m0div2",     32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
    vecs[12] = '{"m5div2",     32'hC0A00000, 32'h40000000, 32'hC0200000, 4'b0000};
    vecs[13] = '{"1div1",      32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
    vecs[14] = '{"3divm3",     32'h40400000, 32'hC0400000, 32'hBF800000, 4'b0000};
    vecs[15] = '{"ovf_edge",   32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010};
    vecs[16] = '{"minnorm",    32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
    vecs[17] = '{"unf_edge",   32'h00800000, 32'h3FC00000, 32'h00000000, 4'b0001};

    bus.start     = 1'b0;
    bus.a_operand = '0;
    bus.b_operand = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   {31'd0, bus.busy},   32'd0);
    chk("rst_done",   {31'd0, bus.done},   32'd0);
    chk("rst_result", bus.result,          32'd0);
    chk("rst_flags",  {28'd0, flags_now()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, fl, bsy, lat);
      chk({vecs[i].name, "_result"},  res,            vecs[i].res);
      chk({vecs[i].name, "_flags"},   {28'd0, fl},    {28'd0, vecs[i].fl});
      chk({vecs[i].name, "_latency"}, lat,            32'd27);
      if (i == 0) chk("done_busy_low", {31'd0, bsy}, 32'd0);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    end

    // start pulsed while busy is ignored; exactly one done with the first result
    @(negedge clk);
    bus.start = 1'b1; bus.a_operand = 32'h40C00000; bus.b_operand = 32'h40000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    ndone = 0; first_done = -1; res1 = '0;
    for (int c = 1; c <= 70; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        if (first_done < 0) begin first_done = c; res1 = bus.result; end
      end
      if (c == 5) begin
        bus.start = 1'b1; bus.a_operand = 32'h3F800000; bus.b_operand = 32'h40400000;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("ignore_ndone",   ndone,      32'd1);
    chk("ignore_latency", first_done, 32'd27);
    chk("ignore_result",  res1,       32'h40400000);

    // reset mid-operation aborts without a done
    @(negedge clk);
    bus.start = 1'b1; bus.a_operand = 32'h3F800000; bus.b_operand = 32'h3F800000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy",   {31'd0, bus.busy}, 32'd0);
    chk("abort_result", bus.result,        32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) ndone++;
    end
    chk("abort_ndone", ndone, 32'd0);

    // start held through the done cycle: back-to-back acceptance
    @(negedge clk);
    bus.start = 1'b1; bus.a_operand = 32'h40C00000; bus.b_operand = 32'h40000000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0; first_done = -1; second_done = -1; res1 = '0; res2 = '0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        ndone++;
        if (first_done < 0) begin first_done = c; res1 = bus.result; end
        else if (second_done < 0) begin second_done = c; res2 = bus.result; end
      end
      if (c >= 26 && c <= 27) begin
        bus.start = 1'b1; bus.a_operand = 32'h40400000; bus.b_operand = 32'hC0400000;
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("b2b_ndone",   ndone,       32'd2);
    chk("b2b_first",   first_done,  32'd27);
    chk("b2b_second",  second_done, 32'd55);
    chk("b2b_result1", res1,        32'h40400000);
    chk("b2b_result2", res2,        32'hBF800000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
